// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register-file write arbiter
package regfile_pkg;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  localparam int NREQ = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; requester 0 wins the first conflict after reset
module rr_arb2
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);
  logic last;
  // grant the lone requester, or on conflict the one that did not win last time
  always_comb begin
    gnt[0] = en & req[0] & (~req[1] | last);
    gnt[1] = en & req[1] & (~req[0] | ~last);
  end
  // remember the most recent winner; untouched while no grant is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last <= 1'b1;
    else last <= gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : last;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares one register-bank write port between two requesters and sequences bank clears
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int NREGS  = 8,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [WIDTH-1:0]  data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  data1,
  output logic              gnt1,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [NREGS-1:0]  reg_we,
  output logic [WIDTH-1:0]  reg_d,
  output logic              addr_err
);
  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic [NREQ-1:0]   gnt;
  logic              en;
  logic              any;
  logic              in_range;
  logic              cnt_last;

  function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] a);
    return {{(NREGS-1){1'b0}}, 1'b1} << a;
  endfunction

  // no grants while in reset, while clearing, or in the cycle a clear is requested
  assign en       = rst & (state == IDLE) & ~clr_start;
  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign clr_busy = state == CLEAR;
  assign cnt_last = cnt == ADDR_W'(NREGS - 1);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .req ({req1, req0}),
    .gnt (gnt)
  );

  // steer the winning requester onto the shared write path
  always_comb begin
    any      = |gnt;
    waddr    = gnt[1] ? addr1 : addr0;
    wdata    = gnt[1] ? data1 : data0;
    in_range = int'(waddr) < NREGS;
  end

  // clear FSM and registered bank-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      reg_we   <= '0;
      reg_d    <= '0;
      addr_err <= 1'b0;
    end else if (state == CLEAR) begin
      reg_we   <= onehot(cnt);
      reg_d    <= '0;
      addr_err <= 1'b0;
      cnt      <= cnt_last ? '0 : cnt + 1'b1;
      state    <= cnt_last ? IDLE : CLEAR;
    end else begin
      state    <= clr_start ? CLEAR : IDLE;
      reg_we   <= (any && in_range) ? onehot(waddr) : '0;
      reg_d    <= any ? wdata : reg_d;
      addr_err <= any & ~in_range;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, clr_start = 1'b0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        gnt0, gnt1, clr_busy, addr_err;
  logic [7:0]  reg_we;
  logic [15:0] reg_d;

  logic        q0 = 1'b0;
  logic [2:0]  qa0 = '0;
  logic [15:0] qd0 = '0;
  logic        q_gnt0, q_gnt1, q_busy, q_err;
  logic [5:0]  q_we;
  logic [15:0] q_d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .reg_we(reg_we), .reg_d(reg_d), .addr_err(addr_err)
  );

  regfile_wr_arbiter #(.WIDTH(16), .NREGS(6)) dut6 (
    .clk(clk), .rst(rst),
    .req0(q0), .addr0(qa0), .data0(qd0), .gnt0(q_gnt0),
    .req1(1'b0), .addr1(3'd0), .data1(16'd0), .gnt1(q_gnt1),
    .clr_start(1'b0), .clr_busy(q_busy),
    .reg_we(q_we), .reg_d(q_d), .addr_err(q_err)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // behavioural model: clear-cycles remaining, last winner and next-cycle expected write
  int          m_last = 1;
  int          m_left = 0;
  int          m_idx = 0;
  logic [7:0]  e_we = '0;
  logic [15:0] e_d = '0;
  logic        e_err = 1'b0;

  always @(negedge clk) begin
    int w;
    int a;
    if (!rst) begin
      chk("m_rst_we", reg_we, 0);
      chk("m_rst_d", reg_d, 0);
      chk("m_rst_busy", clr_busy, 0);
      chk("m_rst_err", addr_err, 0);
      chk("m_rst_gnt", {gnt1, gnt0}, 0);
      m_last = 1; m_left = 0; m_idx = 0; e_we = '0; e_err = 1'b0;
    end else begin
      chk("m_we", reg_we, e_we);
      chk("m_err", addr_err, e_err);
      if (e_we != 0) chk("m_d", reg_d, e_d);
      chk("m_busy", clr_busy, m_left > 0);
      w = -1;
      if (m_left > 0) begin
        e_we = 8'(1) << m_idx; e_d = '0; e_err = 1'b0;
        m_idx++; m_left--;
      end else if (clr_start) begin
        m_left = 8; m_idx = 0; e_we = '0; e_err = 1'b0;
      end else begin
        if (req0 && (!req1 || m_last == 1)) w = 0;
        else if (req1) w = 1;
        e_we = '0; e_err = 1'b0;
        if (w >= 0) begin
          a = (w == 0) ? int'(addr0) : int'(addr1);
          e_d = (w == 0) ? data0 : data1;
          if (a < 8) e_we = 8'(1) << a; else e_err = 1'b1;
          m_last = w;
        end
      end
      chk("m_gnt0", gnt0, w == 0);
      chk("m_gnt1", gnt1, w == 1);
    end
  end

  logic g0s, g1s;
  task automatic tick();
    @(negedge clk);
    g0s = gnt0; g1s = gnt1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_we", reg_we, 0);
    chk("rst_d", reg_d, 0);
    chk("rst_busy", clr_busy, 0);
    rst = 1'b1;
    // contention: four alternating grants, each requester advancing only after its grant
    req0 = 1; addr0 = 0; data0 = 16'h1000;
    req1 = 1; addr1 = 4; data1 = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_gnt0", gnt0, (i % 2) == 0);
      chk("cont_gnt1", gnt1, (i % 2) == 1);
      tick();
      if (g0s) begin addr0++; data0++; end
      if (g1s) begin addr1++; data1++; end
      chk("cont_we", reg_we, (i % 2 == 0) ? (8'(1) << (i / 2)) : (8'(1) << (4 + i / 2)));
      chk("cont_d", reg_d, (i % 2 == 0) ? 16'h1000 + 16'(i / 2) : 16'h2000 + 16'(i / 2));
    end
    req0 = 0; req1 = 0;
    tick();
    chk("idle_we", reg_we, 0);
    // single write
    req1 = 1; addr1 = 3; data1 = 16'hBEEF;
    #1 chk("single_gnt1", gnt1, 1);
    tick();
    req1 = 0;
    chk("single_we", reg_we, 8'b0000_1000);
    chk("single_d", reg_d, 16'hBEEF);
    tick();
    chk("single_we_off", reg_we, 0);
    // clear with a pending request
    req0 = 1; addr0 = 6; data0 = 16'hCAFE; clr_start = 1;
    #1 chk("clr_start_gnt", {gnt1, gnt0}, 0);
    tick();
    clr_start = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("clr_busy", clr_busy, 1);
      chk("clr_gnt0", gnt0, 0);
      chk("clr_we", reg_we, k == 0 ? 8'h00 : (8'(1) << (k - 1)));
      if (k > 0) chk("clr_d", reg_d, 0);
      tick();
    end
    chk("clr_done_busy", clr_busy, 0);
    chk("clr_last_we", reg_we, 8'h80);
    chk("clr_after_gnt0", gnt0, 1);
    tick();
    req0 = 0;
    chk("post_clr_we", reg_we, 8'h40);
    chk("post_clr_d", reg_d, 16'hCAFE);
    // clr_start pulsed mid-clear is ignored
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int k = 0; k < 8; k++) begin
      clr_start = (k == 3);
      #1 chk("abuse_busy", clr_busy, 1);
      tick();
    end
    clr_start = 0;
    chk("abuse_done_busy", clr_busy, 0);
    chk("abuse_last_we", reg_we, 8'h80);
    tick();
    chk("abuse_no_restart", clr_busy, 0);
    // asynchronous reset at counter 4
    clr_start = 1;
    tick();
    clr_start = 0;
    req0 = 1; addr0 = 1; data0 = 16'hAAAA;
    req1 = 1; addr1 = 2; data1 = 16'hBBBB;
    repeat (4) tick();
    chk("mid_busy", clr_busy, 1);
    chk("mid_we", reg_we, 8'h08);
    rst = 1'b0;
    #1;
    chk("arst_we", reg_we, 0);
    chk("arst_d", reg_d, 0);
    chk("arst_busy", clr_busy, 0);
    chk("arst_gnt", {gnt1, gnt0}, 0);
    tick();
    rst = 1'b1;
    #1 chk("rel_gnt0", gnt0, 1);
    chk("rel_busy", clr_busy, 0);
    tick();
    req0 = 0; req1 = 0;
    chk("rel_we", reg_we, 8'h02);
    chk("rel_d", reg_d, 16'hAAAA);
    tick();
    // out-of-range address on the six-register instance
    q0 = 1; qa0 = 7; qd0 = 16'h1234;
    #1 chk("oor_gnt0", q_gnt0, 1);
    tick();
    q0 = 0;
    chk("oor_we", q_we, 0);
    chk("oor_err", q_err, 1);
    tick();
    chk("oor_err_pulse", q_err, 0);
    q0 = 1; qa0 = 5; qd0 = 16'h5555;
    tick();
    q0 = 0;
    chk("top_we", q_we, 6'b10_0000);
    chk("top_err", q_err, 0);
    chk("top_d", q_d, 16'h5555);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Write-side controller for a bank of NREGS parameterizable registers, each WIDTH bits, with per-register write enable.
- Shares the bank's single write path between two requesters using round-robin arbitration.
- Drives the bank's one-hot write enables and the shared data bus from registered outputs.
- Provides a sequenced clear command that zeroes the bank one register per cycle.

Parameters:
- WIDTH, 16, data width of each bank register.
- NREGS, 8, number of registers in the bank; legal range 2..256.
- ADDR_W, $clog2(NREGS), address width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low: rst=0 forces reset immediately, released synchronously to clk.
- req0  in  1  requester 0 write request.
- addr0  in  ADDR_W  requester 0 target register.
- data0  in  WIDTH  requester 0 write data.
- gnt0  out  1  requester 0 accepted this cycle (combinational).
- req1  in  1  requester 1 write request.
- addr1  in  ADDR_W  requester 1 target register.
- data1  in  WIDTH  requester 1 write data.
- gnt1  out  1  requester 1 accepted this cycle (combinational).
- clr_start  in  1  start a bank clear sequence.
- clr_busy  out  1  clear sequence in progress.
- reg_we  out  NREGS  one-hot write enables to the bank (registered).
- reg_d  out  WIDTH  shared write data to the bank (registered).
- addr_err  out  1  one-cycle pulse: an accepted write targeted addr >= NREGS (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - reg_we=0, reg_d=0, addr_err=0, clr_busy=0.
  - FSM goes to IDLE, clear counter=0, last_grant=1, so requester 0 wins the first conflict.
- FSM states: IDLE and CLEAR.
- IDLE, clr_start=1:
  - Go to CLEAR next cycle.
  - No grants are issued in the clr_start cycle.
  - clr_start has priority over requests that cycle.
- IDLE, clr_start=0, arbitration:
  - Exactly one requester active: grant it.
  - Both active: grant the one not equal to last_grant.
  - Update last_grant on every grant.
  - gnt is combinational from req, state and last_grant.
  - A requester holds req/addr/data stable until gnt; req with gnt=1 is a completed handshake.
- Write latency:
  - Grant in cycle N gives, in cycle N+1: reg_we one-hot at the granted addr, reg_d = granted data.
  - reg_we is all-zero in any cycle following a non-grant cycle.
  - Every cycle is independent, with no bubbles: back-to-back grants give back-to-back writes.
- Out-of-range address (only possible when NREGS is not a power of two):
  - The write is still granted.
  - reg_we stays all-zero and addr_err pulses at N+1.
- CLEAR state:
  - clr_busy=1 from the first CLEAR cycle to the last.
  - Each cycle drives reg_we = one-hot(counter), reg_d=0, registered like normal writes.
  - The counter increments each cycle from 0 to NREGS-1.
  - After counter NREGS-1, return to IDLE and reset the counter to 0.
  - CLEAR takes exactly NREGS cycles; the bank is fully zero one cycle after clr_busy falls.
  - gnt0=gnt1=0 throughout; requests stall, they are not dropped.
  - clr_start during CLEAR is ignored (no restart, no queuing).
  - last_grant is unchanged by CLEAR.
- Reset mid-CLEAR: immediate abort, every output zero. Partially cleared registers keep whatever state the bank holds.
- At most one bit of reg_we is ever set (one-hot or zero).

Decomposition:
- Shared package regfile_pkg holds:
  - typedef enum logic {IDLE, CLEAR} clr_state_t
  - localparam requester count (2)
  - function onehot(addr) returning an NREGS-bit vector; its width is tied to the module parameter, so place it in the package as a parameterized-class static function or keep it local to the module.
- One sub-module, rr_arb2: 2-input round-robin arbiter with a last_grant flop and an enable input (deasserted in CLEAR or on clr_start).
- Output registers and the clear FSM stay in the top module.

Test Plan:
- Reset: hold rst=0 mid-traffic -> reg_we=0, reg_d=0, clr_busy=0, gnt0=gnt1=0 immediately (asynchronous); after release, req0=req1=1 -> gnt0=1 first.
- Single write: req1=1, addr1=3, data1=16'hBEEF -> gnt1=1 in cycle N; reg_we=8'b0000_1000, reg_d=16'hBEEF in N+1; reg_we=0 in N+2.
- Contention: req0 and req1 held high for 4 cycles, distinct addrs -> grants alternate 0,1,0,1; four consecutive single-bit reg_we pulses with matching data.
- Clear: clr_start=1 with req0=1 pending, NREGS=8 -> no grant that cycle; clr_busy high 8 cycles; reg_we walks 0x01..0x80 with reg_d=0; gnt0 asserts in the first IDLE cycle afterwards.
- Clear abuse: clr_start pulsed again mid-CLEAR -> still exactly 8 cycles; rst=0 at counter=4 -> outputs zero at once, IDLE after release.
- Out of range (NREGS=6): req0=1, addr0=7 -> gnt0=1; next cycle reg_we=0 and addr_err=1 for one cycle.
